cache_ctrl: RTL and testbench

- Controller FSM that sits directly upstream of the direct-mapped cache array. The array holds 128 one-word lines: tag = addr[31:9], index = addr[8:2].
- Accepts CPU load/store requests and drives the array's en/we/allocate/addr/wdata. Consumes the array's hit/dirty/rdata.
- On a miss, runs a write-back-then-refill sequence against main memory over a req/ack handshake.
- Write-back, write-allocate policy.

---
 rtl/cache_ctrl_if.sv | 58 +++++
 rtl/cache_ctrl.sv | 143 ++++++++++++++
 tb/tb_cache_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// CPU, cache-array and memory signal bundle for the cache controller.
// The slave modport is the controller's view; master is the surrounding system.
interface cache_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 7,
   parameter int CNT_WIDTH  = 32
);
   localparam int BW = DATA_WIDTH / 8;
   localparam int TW = 32 - INDEX_BITS - 2;

   logic                  cpu_valid;
   logic                  cpu_ready;
   logic [31:0]           cpu_addr;
   logic [BW-1:0]         cpu_we;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cpu_done;
   logic [DATA_WIDTH-1:0] cpu_rdata;

   logic                  cm_en;
   logic [BW-1:0]         cm_we;
   logic                  cm_allocate;
   logic [31:0]           cm_addr;
   logic [DATA_WIDTH-1:0] cm_wdata;
   logic [DATA_WIDTH-1:0] cm_rdata;
   logic                  cm_hit;
   logic                  cm_dirty;
   logic [TW-1:0]         cm_victim_tag;

   logic                  mem_req;
   logic                  mem_we;
   logic [31:0]           mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic [CNT_WIDTH-1:0]  hit_count;
   logic [CNT_WIDTH-1:0]  miss_count;

   modport slave (
      input  cpu_valid, cpu_addr, cpu_we, cpu_wdata,
      output cpu_ready, cpu_done, cpu_rdata,
      output cm_en, cm_we, cm_allocate, cm_addr, cm_wdata,
      input  cm_rdata, cm_hit, cm_dirty, cm_victim_tag,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output hit_count, miss_count
   );

   modport master (
      output cpu_valid, cpu_addr, cpu_we, cpu_wdata,
      input  cpu_ready, cpu_done, cpu_rdata,
      input  cm_en, cm_we, cm_allocate, cm_addr, cm_wdata,
      output cm_rdata, cm_hit, cm_dirty, cm_victim_tag,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  hit_count, miss_count
   );
endinterface

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped one-word-line
// cache array; misses run write-back then refill over a req/ack handshake.
module cache_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 7,
   parameter int CNT_WIDTH  = 32
) (
   input logic         clk,
   input logic         rst,
   cache_ctrl_if.slave bus
);
   localparam int BW = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WB, RF, ALLOC, DONE
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic [BW-1:0]         we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  relook_q, relook_d;
   logic [31:0]           vaddr_q, vaddr_d;
   logic [DATA_WIDTH-1:0] vdata_q, vdata_d;
   logic [DATA_WIDTH-1:0] refill_q, refill_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [CNT_WIDTH-1:0]  hit_q, hit_d;
   logic [CNT_WIDTH-1:0]  miss_q, miss_d;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      relook_d = relook_q;
      vaddr_d  = vaddr_q;
      vdata_d  = vdata_q;
      refill_d = refill_q;
      rdata_d  = rdata_q;
      hit_d    = hit_q;
      miss_d   = miss_q;
      unique case (state_q)
         IDLE: begin
            if (bus.cpu_valid) begin
               addr_d   = bus.cpu_addr;
               we_d     = bus.cpu_we;
               wdata_d  = bus.cpu_wdata;
               relook_d = 1'b0;
               state_d  = LOOKUP;
            end
         end
         LOOKUP: begin
            if (bus.cm_hit) begin
               if (we_q == '0)
                  rdata_d = bus.cm_rdata;
               if (!relook_q)
                  hit_d = hit_q + CNT_WIDTH'(1);
               state_d = DONE;
            end else begin
               if (!relook_q)
                  miss_d = miss_q + CNT_WIDTH'(1);
               if (bus.cm_dirty) begin
                  vaddr_d = {bus.cm_victim_tag,
                             addr_q[INDEX_BITS+1:2],
                             2'b00};
                  vdata_d = bus.cm_rdata;
                  state_d = WB;
               end else begin
                  state_d = RF;
               end
            end
         end
         WB: begin
            if (bus.mem_ack)
               state_d = RF;
         end
         RF: begin
            if (bus.mem_ack) begin
               refill_d = bus.mem_rdata;
               state_d  = ALLOC;
            end
         end
         ALLOC: begin
            relook_d = 1'b1;
            state_d  = LOOKUP;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         we_q     <= '0;
         wdata_q  <= '0;
         relook_q <= 1'b0;
         vaddr_q  <= '0;
         vdata_q  <= '0;
         refill_q <= '0;
         rdata_q  <= '0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         relook_q <= relook_d;
         vaddr_q  <= vaddr_d;
         vdata_q  <= vdata_d;
         refill_q <= refill_d;
         rdata_q  <= rdata_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   // Store bytes reach the array in the same cycle the hit is seen.
   always_comb begin
      bus.cm_we = '0;
      if (state_q == ALLOC)
         bus.cm_we = '1;
      else if (state_q == LOOKUP && bus.cm_hit)
         bus.cm_we = we_q;
   end

   assign bus.cpu_ready   = (state_q == IDLE);
   assign bus.cpu_done    = (state_q == DONE);
   assign bus.cpu_rdata   = rdata_q;
   assign bus.cm_en       = (state_q == LOOKUP) || (state_q == ALLOC);
   assign bus.cm_allocate = (state_q == ALLOC);
   assign bus.cm_addr     = addr_q;
   assign bus.cm_wdata    = (state_q == ALLOC) ? refill_q : wdata_q;
   assign bus.mem_req     = (state_q == WB) || (state_q == RF);
   assign bus.mem_we      = (state_q == WB);
   assign bus.mem_addr    = (state_q == WB) ? vaddr_q
                                            : {addr_q[31:2], 2'b00};
   assign bus.mem_wdata   = vdata_q;
   assign bus.hit_count   = hit_q;
   assign bus.miss_count  = miss_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural direct-mapped array
// and a memory responder driven from the request tasks.
module tb_cache_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cache_ctrl_if bus ();

   cache_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // behavioural cache array: 128 one-word lines
   logic [31:0] arr_data [128];
   logic [22:0] arr_tag  [128];
   logic        arr_v    [128];
   logic        arr_d    [128];
   int          cm_wr_cnt = 0;
   logic [6:0]  aidx;

   assign aidx = bus.cm_addr[8:2];

   always_comb begin
      bus.cm_rdata      = arr_data[aidx];
      bus.cm_hit        = arr_v[aidx] && (arr_tag[aidx] == bus.cm_addr[31:9]);
      bus.cm_dirty      = arr_v[aidx] && arr_d[aidx];
      bus.cm_victim_tag = arr_tag[aidx];
   end

   always @(posedge clk) begin
      if (bus.cm_en && bus.cm_allocate) begin
         arr_data[aidx] = bus.cm_wdata;
         arr_tag[aidx]  = bus.cm_addr[31:9];
         arr_v[aidx]    = 1'b1;
         arr_d[aidx]    = 1'b0;
         cm_wr_cnt++;
      end else if (bus.cm_en && bus.cm_hit && bus.cm_we != 4'h0) begin
         for (int b = 0; b < 4; b++)
            if (bus.cm_we[b])
               arr_data[aidx][b*8 +: 8] = bus.cm_wdata[b*8 +: 8];
         arr_d[aidx] = 1'b1;
         cm_wr_cnt++;
      end
   end

   // memory transaction log of the latest request
   logic [31:0] t_addr  [4];
   logic [31:0] t_wdata [4];
   logic        t_we    [4];
   int          n_txn;
   int          unstable;
   int          wait_bad;

   task automatic run_req(input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] wd, input int dly,
                          input logic [31:0] rfd,
                          output logic [31:0] rd, output int lat);
      int wc;
      logic in_ph;
      logic [31:0] p_addr, p_wdata;
      logic p_we;
      n_txn = 0; unstable = 0; wait_bad = 0;
      lat = -1; rd = '0; wc = 0; in_ph = 1'b0;
      p_addr = '0; p_wdata = '0; p_we = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.cpu_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_idle got %b want 1", bus.cpu_ready);
      end
      bus.cpu_valid = 1'b1; bus.cpu_addr = a;
      bus.cpu_we = we; bus.cpu_wdata = wd;
      @(negedge clk);
      bus.cpu_valid = 1'b0; bus.cpu_addr = $urandom;
      bus.cpu_we = 4'($urandom); bus.cpu_wdata = $urandom;
      for (int c = 1; c < 300 && lat < 0; c++) begin
         if (c > 1) @(negedge clk);
         if (bus.cpu_done) begin
            lat = c;
            rd = bus.cpu_rdata;
         end
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            in_ph = 1'b0;
         end else if (bus.mem_req) begin
            if (!in_ph) begin
               in_ph = 1'b1; wc = 0;
               p_addr = bus.mem_addr; p_wdata = bus.mem_wdata;
               p_we = bus.mem_we;
            end else if (p_addr !== bus.mem_addr || p_we !== bus.mem_we ||
                         (p_we && p_wdata !== bus.mem_wdata)) begin
               unstable++;
            end
            if (bus.cpu_ready || bus.cm_en || bus.cm_we != 4'h0)
               wait_bad++;
            wc++;
            if (wc == dly) begin
               bus.mem_ack = 1'b1;
               bus.mem_rdata = rfd;
               if (n_txn < 4) begin
                  t_addr[n_txn] = bus.mem_addr;
                  t_wdata[n_txn] = bus.mem_wdata;
                  t_we[n_txn] = bus.mem_we;
               end
               n_txn++;
            end
         end
      end
      if (lat < 0) begin
         checks++; errors++;
         $display("FAIL req_timeout addr %h got no done want done", a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.cpu_ready !== 1'b1) begin
         errors++; $display("FAIL rst_ready got %b want 1", bus.cpu_ready);
      end
      checks++;
      if ({bus.cpu_done, bus.mem_req, bus.cm_en, bus.cm_allocate} !== 4'b0) begin
         errors++;
         $display("FAIL rst_ctl got %b%b%b%b want 0000", bus.cpu_done,
                  bus.mem_req, bus.cm_en, bus.cm_allocate);
      end
      checks++;
      if (bus.cm_we !== 4'h0 || bus.cpu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_data got we %h rdata %h want 0 0",
                  bus.cm_we, bus.cpu_rdata);
      end
      checks++;
      if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_cnt got %0d/%0d want 0/0",
                  bus.hit_count, bus.miss_count);
      end
      rst = 1'b0;
   endtask

   task automatic test_clean_miss();
      logic [31:0] rd;
      int lat;
      run_req(32'h0000_0104, 4'h0, 32'h0, 3, 32'hDEADBEEF, rd, lat);
      checks++;
      if (n_txn !== 1 || t_we[0] !== 1'b0 || t_addr[0] !== 32'h104) begin
         errors++;
         $display("FAIL cm_txn got n %0d we %b addr %h want 1 0 104",
                  n_txn, t_we[0], t_addr[0]);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL cm_rdata got %h want deadbeef", rd);
      end
      run_req(32'h0000_0104, 4'h0, 32'h0, 3, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'hDEADBEEF || lat !== 2 || n_txn !== 0) begin
         errors++;
         $display("FAIL hit_load got %h lat %0d n %0d want deadbeef 2 0",
                  rd, lat, n_txn);
      end
      checks++;
      if (bus.hit_count !== 32'd1 || bus.miss_count !== 32'd1) begin
         errors++;
         $display("FAIL cm_cnt got %0d/%0d want 1/1",
                  bus.hit_count, bus.miss_count);
      end
   endtask

   task automatic test_store_hit();
      logic [31:0] rd;
      int lat;
      run_req(32'h0000_0104, 4'b0011, 32'h0000_1234, 3, 32'h0, rd, lat);
      checks++;
      if (n_txn !== 0 || lat !== 2 || arr_d[7'h41] !== 1'b1) begin
         errors++;
         $display("FAIL sh_store got n %0d lat %0d dirty %b want 0 2 1",
                  n_txn, lat, arr_d[7'h41]);
      end
      run_req(32'h0000_0104, 4'h0, 32'h0, 3, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'hDEAD1234 || n_txn !== 0) begin
         errors++;
         $display("FAIL sh_load got %h n %0d want dead1234 0", rd, n_txn);
      end
      checks++;
      if (bus.hit_count !== 32'd3 || bus.miss_count !== 32'd1) begin
         errors++;
         $display("FAIL sh_cnt got %0d/%0d want 3/1",
                  bus.hit_count, bus.miss_count);
      end
   endtask

   task automatic test_dirty_evict();
      logic [31:0] rd;
      int lat;
      run_req(32'h0000_0304, 4'h0, 32'h0, 2, 32'h55AA55AA, rd, lat);
      checks++;
      if (n_txn !== 2 || t_we[0] !== 1'b1 || t_addr[0] !== 32'h104 ||
          t_wdata[0] !== 32'hDEAD1234) begin
         errors++;
         $display("FAIL de_wb got n %0d we %b addr %h data %h want 2 1 104 dead1234",
                  n_txn, t_we[0], t_addr[0], t_wdata[0]);
      end
      checks++;
      if (t_we[1] !== 1'b0 || t_addr[1] !== 32'h304) begin
         errors++;
         $display("FAIL de_rf got we %b addr %h want 0 304",
                  t_we[1], t_addr[1]);
      end
      checks++;
      if (rd !== 32'h55AA55AA || bus.miss_count !== 32'd2) begin
         errors++;
         $display("FAIL de_res got %h miss %0d want 55aa55aa 2",
                  rd, bus.miss_count);
      end
   endtask

   task automatic test_store_miss();
      logic [31:0] rd;
      int lat;
      run_req(32'h0000_0508, 4'hF, 32'hCAFEF00D, 2, 32'h11111111, rd, lat);
      checks++;
      if (n_txn !== 1 || t_we[0] !== 1'b0 || t_addr[0] !== 32'h508) begin
         errors++;
         $display("FAIL sm_txn got n %0d we %b addr %h want 1 0 508",
                  n_txn, t_we[0], t_addr[0]);
      end
      checks++;
      if (arr_data[7'h42] !== 32'hCAFEF00D || arr_d[7'h42] !== 1'b1) begin
         errors++;
         $display("FAIL sm_line got %h dirty %b want cafef00d 1",
                  arr_data[7'h42], arr_d[7'h42]);
      end
      checks++;
      if (bus.hit_count !== 32'd3 || bus.miss_count !== 32'd3) begin
         errors++;
         $display("FAIL sm_cnt got %0d/%0d want 3/3",
                  bus.hit_count, bus.miss_count);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      int lat;
      run_req(32'h0000_0708, 4'h0, 32'h0, 20, 32'h77777777, rd, lat);
      checks++;
      if (unstable !== 0 || wait_bad !== 0) begin
         errors++;
         $display("FAIL bp_stable got unstable %0d bad %0d want 0 0",
                  unstable, wait_bad);
      end
      checks++;
      if (n_txn !== 2 || t_addr[0] !== 32'h508 || t_wdata[0] !== 32'hCAFEF00D ||
          t_addr[1] !== 32'h708) begin
         errors++;
         $display("FAIL bp_txn got n %0d %h %h %h want 2 508 cafef00d 708",
                  n_txn, t_addr[0], t_wdata[0], t_addr[1]);
      end
      checks++;
      if (rd !== 32'h77777777 || bus.miss_count !== 32'd4) begin
         errors++;
         $display("FAIL bp_res got %h miss %0d want 77777777 4",
                  rd, bus.miss_count);
      end
   endtask

   task automatic test_async_reset();
      int wr0;
      logic seen_done;
      @(negedge clk);
      bus.cpu_valid = 1'b1; bus.cpu_addr = 32'h0000_090C;
      bus.cpu_we = 4'h0; bus.cpu_wdata = 32'h0;
      @(negedge clk);
      bus.cpu_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h90C) begin
         errors++;
         $display("FAIL ar_rf got req %b addr %h want 1 90c",
                  bus.mem_req, bus.mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b1 || bus.cm_en !== 1'b0) begin
         errors++;
         $display("FAIL ar_now got req %b ready %b en %b want 0 1 0",
                  bus.mem_req, bus.cpu_ready, bus.cm_en);
      end
      @(negedge clk);
      rst = 1'b0;
      wr0 = cm_wr_cnt;
      seen_done = 1'b0;
      @(negedge clk);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBADBAD00;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.cpu_done) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0 || cm_wr_cnt !== wr0 || arr_v[7'h43] !== 1'b0) begin
         errors++;
         $display("FAIL ar_late got done %b writes %0d valid %b want 0 %0d 0",
                  seen_done, cm_wr_cnt, arr_v[7'h43], wr0);
      end
      checks++;
      if (bus.cpu_ready !== 1'b1 || bus.miss_count !== 32'd0 ||
          bus.hit_count !== 32'd0) begin
         errors++;
         $display("FAIL ar_idle got ready %b cnt %0d/%0d want 1 0/0",
                  bus.cpu_ready, bus.hit_count, bus.miss_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int lat;
      run_req(32'h0000_0304, 4'h0, 32'h0, 1, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h55AA55AA || lat !== 2 || n_txn !== 0) begin
         errors++;
         $display("FAIL bb_a got %h lat %0d n %0d want 55aa55aa 2 0",
                  rd, lat, n_txn);
      end
      run_req(32'h0000_0708, 4'h0, 32'h0, 1, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h77777777 || lat !== 2 || n_txn !== 0) begin
         errors++;
         $display("FAIL bb_b got %h lat %0d n %0d want 77777777 2 0",
                  rd, lat, n_txn);
      end
      checks++;
      if (bus.hit_count !== 32'd2 || bus.miss_count !== 32'd0) begin
         errors++;
         $display("FAIL bb_cnt got %0d/%0d want 2/0",
                  bus.hit_count, bus.miss_count);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         arr_data[i] = '0; arr_tag[i] = '0;
         arr_v[i] = 1'b0; arr_d[i] = 1'b0;
      end
      bus.cpu_valid = 1'b0; bus.cpu_addr = '0;
      bus.cpu_we = '0; bus.cpu_wdata = '0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      test_reset();
      test_clean_miss();
      test_store_hit();
      test_dirty_evict();
      test_store_miss();
      test_backpressure();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
